decode_stage: RTL and testbench

Instruction-decode stage of the LC-3b pipeline, between the IF/ID and ID/EX pipeline latches. Holds the 8x16 architectural register file, generates the 16-bit control word, reads source operands with write-through bypass from writeback, and detects load-use hazards. On a hazard it freezes IF/ID and injects a bubble into ID/EX. Keeps a saturating count of injected bubbles for performance monitoring.

---
 rtl/decode_stage.sv | 139 +++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// LC-3b decode stage: register file with writeback bypass, control-word generation,
// load-use hazard detection with bubble injection, and a saturating bubble counter.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR_in,
    input  logic [15:0] PC_in,
    input  logic        valid_in,
    input  logic [15:0] ex_ir,
    input  logic        ex_valid,
    input  logic        mem_stall,
    input  logic        wb_load,
    input  logic [2:0]  wb_dest,
    input  logic [15:0] wb_data,
    output logic [15:0] IR_out,
    output logic [15:0] PC_out,
    output logic [15:0] CW_out,
    output logic [15:0] SR1_out,
    output logic [15:0] SR2_out,
    output logic        valid_out,
    output logic        load_ifid,
    output logic        load_idex,
    output logic [15:0] bubble_count
);

    typedef enum logic [3:0] {
        OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
        OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
        OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
        OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } opcode_e;

    logic [15:0] regs_q [8];
    logic [15:0] count_q, count_d;

    opcode_e     op, ex_op;
    logic [2:0]  sr1_idx, sr2_idx, dest;
    logic        sr1_used, sr2_used;
    logic        regwrite, load_cc, mem_read, mem_write, imm_sel;
    logic [15:0] cw;
    logic [15:0] sr1_val, sr2_val;
    logic        ex_is_load, hazard, bubble;
    logic        unused_ex_bits;

    assign op             = opcode_e'(IR_in[15:12]);
    assign ex_op          = opcode_e'(ex_ir[15:12]);
    assign unused_ex_bits = ^ex_ir[8:0];

    always_comb begin
        sr1_idx   = IR_in[8:6];
        sr2_idx   = IR_in[2:0];
        sr1_used  = 1'b0;
        sr2_used  = 1'b0;
        regwrite  = 1'b0;
        load_cc   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (op)
            OP_ADD, OP_AND: begin
                sr1_used = 1'b1;
                sr2_used = ~IR_in[5];
                regwrite = 1'b1;
                load_cc  = 1'b1;
            end
            OP_NOT, OP_SHF: begin
                sr1_used = 1'b1;
                regwrite = 1'b1;
                load_cc  = 1'b1;
            end
            OP_LEA: begin
                regwrite = 1'b1;
                load_cc  = 1'b1;
            end
            OP_LDB, OP_LDR, OP_LDI: begin
                sr1_used = 1'b1;
                regwrite = 1'b1;
                load_cc  = 1'b1;
                mem_read = 1'b1;
            end
            OP_STB, OP_STR, OP_STI: begin
                sr1_used  = 1'b1;
                sr2_used  = 1'b1;
                sr2_idx   = IR_in[11:9];
                mem_write = 1'b1;
            end
            OP_JSR: begin
                sr1_used = ~IR_in[11];
                regwrite = 1'b1;
            end
            OP_JMP:  sr1_used = 1'b1;
            OP_TRAP: begin
                regwrite = 1'b1;
                mem_read = 1'b1;
            end
            default: ;
        endcase
        dest    = (op == OP_JSR || op == OP_TRAP) ? 3'd7 : IR_in[11:9];
        imm_sel = (op == OP_ADD || op == OP_AND) & IR_in[5];
    end

    assign cw = {IR_in[15:12], regwrite, load_cc, mem_read, mem_write, imm_sel, dest, 4'b0000};

    // Write-through: a same-cycle writeback to the read index wins over the stored value.
    always_comb begin
        sr1_val = regs_q[sr1_idx];
        sr2_val = regs_q[sr2_idx];
        if (wb_load && wb_dest == sr1_idx) sr1_val = wb_data;
        if (wb_load && wb_dest == sr2_idx) sr2_val = wb_data;
    end

    assign ex_is_load = ex_valid & (ex_op == OP_LDB || ex_op == OP_LDR || ex_op == OP_LDI);
    assign hazard     = valid_in & ex_is_load &
                        ((sr1_used & (sr1_idx == ex_ir[11:9])) |
                         (sr2_used & (sr2_idx == ex_ir[11:9])));
    assign bubble     = hazard & ~mem_stall;

    assign IR_out       = bubble ? '0 : IR_in;
    assign PC_out       = PC_in;
    assign CW_out       = (bubble | ~valid_in) ? '0 : cw;
    assign SR1_out      = sr1_val;
    assign SR2_out      = sr2_val;
    assign valid_out    = valid_in & ~bubble;
    assign load_ifid    = ~mem_stall & ~hazard;
    assign load_idex    = ~mem_stall;
    assign bubble_count = count_q;

    assign count_d = (bubble && count_q != '1) ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
            count_q <= '0;
        end else begin
            if (wb_load) regs_q[wb_dest] <= wb_data;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand sequences for
// bypass / load-use / reset / saturation, and random stimulus against an opcode-set model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IR_in, PC_in, ex_ir, wb_data;
    logic        valid_in, ex_valid, mem_stall, wb_load;
    logic [2:0]  wb_dest;
    logic [15:0] IR_out, PC_out, CW_out, SR1_out, SR2_out, bubble_count;
    logic        valid_out, load_ifid, load_idex;

    int checks = 0;
    int failures = 0;

    logic [15:0] mregs [8];
    logic [15:0] mcount;

    decode_stage dut (
        .clk(clk), .reset(reset), .IR_in(IR_in), .PC_in(PC_in), .valid_in(valid_in),
        .ex_ir(ex_ir), .ex_valid(ex_valid), .mem_stall(mem_stall), .wb_load(wb_load),
        .wb_dest(wb_dest), .wb_data(wb_data), .IR_out(IR_out), .PC_out(PC_out),
        .CW_out(CW_out), .SR1_out(SR1_out), .SR2_out(SR2_out), .valid_out(valid_out),
        .load_ifid(load_ifid), .load_idex(load_idex), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ex;
        logic        ev;
        logic        vi;
        logic        ms;
        logic [15:0] cw;
        logic        lif;
        logic        lid;
        logic        vo;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Opcode membership sets: bit k of each mask means opcode k belongs to the set.
    function automatic void model(input logic [15:0] ir, input logic [15:0] ex, input logic ev,
                                  input logic vi, output logic [15:0] cw, output logic haz,
                                  output logic [2:0] i1, output logic [2:0] i2);
        logic [15:0] m_sr1   = 16'h3EEE;
        logic [15:0] m_store = 16'h0888;
        logic [15:0] m_rw    = 16'hE676;
        logic [15:0] m_lcc   = 16'h6666;
        logic [15:0] m_mr    = 16'h8444;
        logic [15:0] m_load  = 16'h0444;
        logic [15:0] m_alu   = 16'h0022;
        int          op      = int'(ir[15:12]);
        int          xop     = int'(ex[15:12]);
        logic        u1, u2;
        logic [2:0]  dst;
        u1  = m_sr1[op] | (op == 4 && !ir[11]);
        i1  = ir[8:6];
        i2  = m_store[op] ? ir[11:9] : ir[2:0];
        u2  = m_store[op] | (m_alu[op] & !ir[5]);
        dst = (op == 4 || op == 15) ? 3'd7 : ir[11:9];
        cw  = {ir[15:12], m_rw[op], m_lcc[op], m_mr[op], m_store[op], m_alu[op] & ir[5], dst, 4'h0};
        haz = vi && ev && m_load[xop] && ((u1 && i1 == ex[11:9]) || (u2 && i2 == ex[11:9]));
    endfunction

    function automatic logic [15:0] mread(input logic [2:0] idx);
        return (wb_load && wb_dest == idx) ? wb_data : mregs[idx];
    endfunction

    task automatic check_outputs(input string tag);
        logic [15:0] cw;
        logic        haz, bub;
        logic [2:0]  i1, i2;
        model(IR_in, ex_ir, ex_valid, valid_in, cw, haz, i1, i2);
        bub = haz && !mem_stall;
        chk({tag, "/ir"},  IR_out,  bub ? 16'h0 : IR_in);
        chk({tag, "/pc"},  PC_out,  PC_in);
        chk({tag, "/cw"},  CW_out,  (bub || !valid_in) ? 16'h0 : cw);
        chk({tag, "/sr1"}, SR1_out, mread(i1));
        chk({tag, "/sr2"}, SR2_out, mread(i2));
        chk({tag, "/vo"},  16'(valid_out), 16'(valid_in && !bub));
        chk({tag, "/lif"}, 16'(load_ifid), 16'(!mem_stall && !haz));
        chk({tag, "/lid"}, 16'(load_idex), 16'(!mem_stall));
        chk({tag, "/cnt"}, bubble_count, mcount);
    endtask

    // Advance one clock: update the model at the rising edge, return at the falling edge.
    task automatic clock_edge();
        logic [15:0] cw;
        logic        haz;
        logic [2:0]  i1, i2;
        @(posedge clk);
        model(IR_in, ex_ir, ex_valid, valid_in, cw, haz, i1, i2);
        if (!reset) begin
            if (wb_load) mregs[wb_dest] = wb_data;
            if (!mem_stall && haz && mcount != 16'hFFFF) mcount = mcount + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] ir, input logic [15:0] ex, input logic ev,
                         input logic vi, input logic ms);
        IR_in = ir; ex_ir = ex; ex_valid = ev; valid_in = vi; mem_stall = ms;
        PC_in = PC_in + 16'd2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        mcount = 16'h0;
    endtask

    initial begin
        reset = 1'b1;
        IR_in = 16'h0; PC_in = 16'h3000; ex_ir = 16'h0; wb_data = 16'h0;
        valid_in = 1'b0; ex_valid = 1'b0; mem_stall = 1'b0; wb_load = 1'b0; wb_dest = 3'd0;
        model_reset();

        //          ir       ex       ev    vi    ms    cw       lif   lid   vo
        vecs[0]  = '{16'h1283, 16'h6400, 1'b0, 1'b1, 1'b0, 16'h1C10, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{16'h1283, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h12E2, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h1C90, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{16'h7400, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h7400, 16'h6400, 1'b1, 1'b1, 1'b1, 16'h7120, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'h1283, 16'h6400, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16'h6400, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h6E20, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{16'h4800, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h4870, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'h4080, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'hF025, 16'h6400, 1'b1, 1'b1, 1'b0, 16'hFA70, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{16'h92BF, 16'h7400, 1'b1, 1'b1, 1'b0, 16'h9C10, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{16'h1283, 16'hA400, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{16'h1202, 16'h2400, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{16'h0E05, 16'h6400, 1'b1, 1'b1, 1'b0, 16'h0070, 1'b1, 1'b1, 1'b1};

        @(negedge clk);
        chk("reset/cnt", bubble_count, 16'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].ir, vecs[k].ex, vecs[k].ev, vecs[k].vi, vecs[k].ms);
            #1;
            chk($sformatf("vec%0d/cw", k),  CW_out, vecs[k].cw);
            chk($sformatf("vec%0d/lif", k), 16'(load_ifid), 16'(vecs[k].lif));
            chk($sformatf("vec%0d/lid", k), 16'(load_idex), 16'(vecs[k].lid));
            chk($sformatf("vec%0d/vo", k),  16'(valid_out), 16'(vecs[k].vo));
            check_outputs($sformatf("vec%0d", k));
            clock_edge();
        end
        chk("table/cnt", bubble_count, 16'd5);

        // Write-through bypass, then the stored value on the following cycle.
        drive(16'h1283, 16'h0000, 1'b0, 1'b1, 1'b0);
        wb_load = 1'b1; wb_dest = 3'd2; wb_data = 16'hBEEF;
        #1;
        chk("bypass/sr1", SR1_out, 16'hBEEF);
        check_outputs("bypass");
        clock_edge();
        wb_load = 1'b0;
        #1;
        chk("stored/sr1", SR1_out, 16'hBEEF);
        check_outputs("stored");
        clock_edge();

        // Load-use bubble lasts one cycle, then the held instruction issues.
        drive(16'h1283, 16'h6400, 1'b1, 1'b1, 1'b0);
        #1;
        check_outputs("lu_bubble");
        clock_edge();
        chk("lu_cnt", bubble_count, 16'd6);
        drive(16'h1283, 16'h0000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu_issue/cw", CW_out, 16'h1C10);
        check_outputs("lu_issue");
        clock_edge();

        for (int n = 0; n < 400; n++) begin
            logic [15:0] ir, ex;
            ir = 16'($urandom);
            ex = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: ex[15:12] = 4'h2;
                    1: ex[15:12] = 4'h6;
                    default: ex[15:12] = 4'hA;
                endcase
            end
            if ($urandom_range(0, 1) == 1) ex[11:9] = ($urandom_range(0, 1) == 1) ? ir[8:6] : ir[2:0];
            drive(ir, ex, $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 5) == 0);
            wb_load = 1'($urandom_range(0, 1));
            wb_dest = 3'($urandom_range(0, 7));
            wb_data = 16'($urandom);
            #1;
            check_outputs("rand");
            clock_edge();
        end
        wb_load = 1'b0;

        // Asynchronous reset between edges, and writes ignored while it is held.
        mregs[2] = 16'hBEEF;
        drive(16'h1283, 16'h0000, 1'b0, 1'b1, 1'b0);
        wb_load = 1'b1; wb_dest = 3'd2; wb_data = 16'hBEEF;
        clock_edge();
        wb_load = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("areset/cnt", bubble_count, 16'h0);
        chk("areset/sr1", SR1_out, 16'h0);
        check_outputs("areset");
        wb_load = 1'b1; wb_dest = 3'd2; wb_data = 16'h1234;
        #1;
        chk("rst_bypass/sr1", SR1_out, 16'h1234);
        clock_edge();
        reset = 1'b0; wb_load = 1'b0;
        #1;
        chk("rst_nowrite/sr1", SR1_out, 16'h0);
        check_outputs("rst_nowrite");

        // Saturation: hold a load-use hazard for more than 0x10000 cycles.
        drive(16'h1283, 16'h6400, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 65534; n++) clock_edge();
        chk("sat/fffe", bubble_count, 16'hFFFE);
        clock_edge();
        chk("sat/ffff", bubble_count, 16'hFFFF);
        clock_edge();
        clock_edge();
        chk("sat/hold", bubble_count, 16'hFFFF);
        check_outputs("sat");

        // mem_stall wins over a hazard: no bubble, both latches frozen.
        mem_stall = 1'b1;
        #1;
        chk("ms/lif", 16'(load_ifid), 16'h0);
        chk("ms/lid", 16'(load_idex), 16'h0);
        check_outputs("ms");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("sat_reset/cnt", bubble_count, 16'h0);
        clock_edge();
        chk("ms_cnt", bubble_count, 16'h0);
        reset = 1'b0;
        clock_edge();
        chk("ms_hold_cnt", bubble_count, 16'h0);
        check_outputs("ms_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
